uart_tx_fifo: RTL and testbench

Transmit-side byte buffer that sits directly upstream of the UART transmitter. Host logic pushes bytes at system-clock rate. The block stores them in a circular FIFO and feeds them one at a time to the transmitter's `newd`/`tx_data` inputs. Each byte is paced by the transmitter's `done_tx` completion flag, so no byte is lost or sent twice even though the transmitter runs on its own slow baud clock.

---
 rtl/uart_tx_fifo_if.sv | 29 ++
 rtl/uart_tx_fifo.sv | 98 +++++++++
 tb/tb_uart_tx_fifo.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between host logic, the transmit FIFO and the UART transmitter.
// The slave modport is the FIFO; the master modport is everything around it.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          newd;
  logic [DW-1:0] din;
  logic          donetx;
  logic          busy;

  modport master (
    output wr_en, wr_data, donetx,
    input  full, empty, count, overflow, newd, din, busy
  );

  modport slave (
    input  wr_en, wr_data, donetx,
    output full, empty, count, overflow, newd, din, busy
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular transmit FIFO feeding a UART transmitter one byte per frame,
// paced by the transmitter's done_tx flag (rising edge completes a byte).
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input logic          clk,
  input logic          rst,
  uart_tx_fifo_if.slave bus
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SEND  = 2'b01,
    DRAIN = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count_q;
  logic          newd_q, newd_d;
  logic [DW-1:0] din_q;
  logic          overflow_q;
  logic          dt_q;
  logic          full_w;
  logic          pop;
  logic          push;
  logic          dt_rise;

  assign full_w  = (count_q == FULL_CNT);
  assign dt_rise = bus.donetx && !dt_q;
  // A full FIFO still accepts a push when the same edge frees a slot by popping.
  assign push    = bus.wr_en && (!full_w || pop);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND:    if (dt_rise) state_d = DRAIN;
      DRAIN:   if (!bus.donetx) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    newd_d = (state_d == SEND);
  end

  // NOTE: storage has no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= bus.wr_data;
  end

  // NOTE: non-blocking reads of mem[rp] see the pre-edge contents, so a push and pop
  // to the same slot (full FIFO) hands out the old byte and stores the new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wp         <= '0;
      rp         <= '0;
      count_q    <= '0;
      newd_q     <= 1'b0;
      din_q      <= '0;
      overflow_q <= 1'b0;
      dt_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      newd_q     <= newd_d;
      dt_q       <= bus.donetx;
      overflow_q <= bus.wr_en && full_w && !pop;
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        rp    <= rp + 1'b1;
        din_q <= mem[rp];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.full     = full_w;
  assign bus.empty    = (count_q == '0);
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.newd     = newd_q;
  assign bus.din      = din_q;
  assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed timing checks plus randomized streaming, with
// a queue scoreboard of accepted bytes against bytes presented on newd/din.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int DW    = 8;

  logic clk;
  logic rst;
  logic tx_auto;
  logic auto_done;
  logic man_done;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int            got_ptr;

  uart_tx_fifo_if #(.DEPTH(DEPTH), .DW(DW)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.donetx = tx_auto ? auto_done : man_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every newd rising edge presents one byte to the transmitter.
  initial begin
    logic prev_newd;
    prev_newd = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.newd && !prev_newd) got_q.push_back(bus.din);
      prev_newd = bus.newd;
    end
  end

  // Transmitter model: random frame length, done held until newd drops.
  initial begin
    auto_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_auto && bus.newd) begin
        repeat ($urandom_range(2, 10)) @(negedge clk);
        auto_done = 1'b1;
        for (int i = 0; i < 50 && bus.newd; i++) @(negedge clk);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        auto_done = 1'b0;
        @(negedge clk);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_now(input logic [DW-1:0] b, input bit expect_accept);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    if (expect_accept) exp_q.push_back(b);
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((bus.busy || !bus.empty) && n < 4000) begin
      tick();
      n++;
    end
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_idle_empty"}, 32'(bus.empty), 32'd1);
  endtask

  task automatic compare_stream(input string tag);
    int n_exp;
    wait_idle(tag);
    n_exp = exp_q.size();
    check({tag, "_len"}, 32'(got_q.size() - got_ptr), 32'(n_exp));
    for (int i = 0; i < n_exp; i++)
      if (got_ptr + i < got_q.size())
        check({tag, "_byte"}, 32'(got_q[got_ptr + i]), 32'(exp_q[i]));
    got_ptr = got_q.size();
    exp_q.delete();
  endtask

  // Push that is guaranteed to be accepted: stalls while the FIFO is nearly full.
  task automatic push_throttled(input logic [DW-1:0] b);
    int n;
    n = 0;
    while (bus.count >= 14 && n < 4000) begin
      tick();
      n++;
    end
    push_now(b, 1'b1);
    check("stream_overflow", 32'(bus.overflow), 32'd0);
    repeat ($urandom_range(0, 3)) tick();
  endtask

  initial begin
    int exp_cnt[3];
    exp_cnt = '{1, 1, 2};

    rst         = 1'b1;
    tx_auto     = 1'b0;
    man_done    = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    got_ptr     = 0;
    tick();
    tick();

    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_newd", 32'(bus.newd), 32'd0);
    check("rst_din", 32'(bus.din), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    rst = 1'b0;
    tick();

    // Single byte with exact timing.
    push_now(8'hA5, 1'b1);
    check("single_k_count", 32'(bus.count), 32'd1);
    check("single_k_empty", 32'(bus.empty), 32'd0);
    check("single_k_newd", 32'(bus.newd), 32'd0);
    tick();
    check("single_k1_newd", 32'(bus.newd), 32'd1);
    check("single_k1_din", 32'(bus.din), 32'hA5);
    check("single_k1_count", 32'(bus.count), 32'd0);
    check("single_k1_empty", 32'(bus.empty), 32'd1);
    check("single_k1_busy", 32'(bus.busy), 32'd1);
    repeat (3) tick();
    check("single_hold_newd", 32'(bus.newd), 32'd1);
    man_done = 1'b1;
    tick();
    check("single_done_newd", 32'(bus.newd), 32'd0);
    check("single_drain_busy", 32'(bus.busy), 32'd1);
    tick();
    check("single_drain_hold", 32'(bus.busy), 32'd1);
    man_done = 1'b0;
    tick();
    check("single_idle_busy", 32'(bus.busy), 32'd0);
    compare_stream("single");

    // Ordering: three consecutive pushes, count peaks at 2.
    for (int i = 0; i < 3; i++) begin
      push_now(8'(i + 1), 1'b1);
      if (i < 2) bus.wr_en = 1'b0;
      check("order_count", 32'(bus.count), 32'(exp_cnt[i]));
    end
    tx_auto = 1'b1;
    compare_stream("order");
    tx_auto = 1'b0;

    // Full and overflow with the transmitter stalled on 0x80.
    push_now(8'h80, 1'b1);
    tick();
    for (int i = 0; i < DEPTH; i++) push_now(8'(8'h81 + i), 1'b1);
    check("full_count", 32'(bus.count), 32'd16);
    check("full_flag", 32'(bus.full), 32'd1);
    check("full_no_ovf", 32'(bus.overflow), 32'd0);
    push_now(8'h91, 1'b0);
    check("ovf_pulse", 32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.count), 32'd16);
    tick();
    check("ovf_clear", 32'(bus.overflow), 32'd0);
    push_now(8'h92, 1'b0);
    check("ovf_pulse2", 32'(bus.overflow), 32'd1);
    tick();
    check("ovf_clear2", 32'(bus.overflow), 32'd0);

    // Release the stalled frame, then push exactly on the IDLE pop cycle.
    man_done = 1'b1;
    tick();
    check("sim_drain_newd", 32'(bus.newd), 32'd0);
    man_done = 1'b0;
    tick();
    check("sim_idle_busy", 32'(bus.busy), 32'd0);
    check("sim_idle_full", 32'(bus.full), 32'd1);
    push_now(8'h93, 1'b1);
    check("sim_count", 32'(bus.count), 32'd16);
    check("sim_full", 32'(bus.full), 32'd1);
    check("sim_overflow", 32'(bus.overflow), 32'd0);
    check("sim_newd", 32'(bus.newd), 32'd1);
    check("sim_din", 32'(bus.din), 32'h81);
    tx_auto = 1'b1;
    compare_stream("full");

    // Wrap-around with an ascending stream, then random bytes.
    for (int i = 0; i < 40; i++) push_throttled(8'(i));
    compare_stream("wrap");
    for (int i = 0; i < 60; i++) push_throttled(8'($urandom));
    compare_stream("rand");
    tx_auto = 1'b0;

    // Reset mid-frame with five bytes queued behind 0x55.
    push_now(8'h55, 1'b1);
    tick();
    check("mid_newd", 32'(bus.newd), 32'd1);
    for (int i = 0; i < 5; i++) push_now(8'($urandom), 1'b0);
    check("mid_count", 32'(bus.count), 32'd5);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_empty", 32'(bus.empty), 32'd1);
    check("mid_rst_newd", 32'(bus.newd), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_full", 32'(bus.full), 32'd0);
    check("mid_rst_din", 32'(bus.din), 32'd0);
    compare_stream("mid_inflight");

    // Fresh byte after reset with donetx left high: stale flag must not complete it.
    man_done = 1'b1;
    push_now(8'h3C, 1'b1);
    tick();
    check("stale_newd", 32'(bus.newd), 32'd1);
    check("stale_din", 32'(bus.din), 32'h3C);
    repeat (3) tick();
    check("stale_hold", 32'(bus.newd), 32'd1);
    man_done = 1'b0;
    tick();
    man_done = 1'b1;
    tick();
    check("stale_done_newd", 32'(bus.newd), 32'd0);
    man_done = 1'b0;
    tick();
    tick();
    compare_stream("after_rst");
    check("no_extra_frames", 32'(got_q.size()), 32'(got_ptr));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
